// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Purpose:
//    Program-counter update unit. Holds the registered PC and exception PC and
//    decides each cycle whether the PC is loaded from one of NSRC sources,
//    redirected to the exception vector, or held. A small two-state FSM
//    (RUN / FAULT) parks the unit after a misaligned branch target when the
//    optional alignment check is built in.
//
// Parameters:
//    WIDTH         PC, EPC and per-source data width
//    NSRC          number of PC sources (2..16)
//    RESET_VECTOR  PC value loaded on reset
//    EXC_VECTOR    PC value loaded on an exception redirect
//
// Ports:
//    clk            in   single clock, rising edge
//    reset          in   synchronous active-high reset
//    sel            in   source index, max(1,clog2(NSRC)) bits
//    src_data       in   flattened sources, source i at [i*WIDTH +: WIDTH]
//    pc_write       in   unconditional PC load request
//    pc_write_cond  in   PC load request gated by cond_zero
//    cond_zero      in   branch condition (ALU zero)
//    exc_req        in   exception redirect request
//    fault_clr      in   leave the FAULT state
//    pc_out         out  registered program counter
//    epc_out        out  registered exception PC
//    pc_updated     out  one-cycle pulse after every PC load/redirect
//    fault          out  high while in FAULT
//    sel_err        out  one-cycle pulse after a load with out-of-range sel
//
// Build option:
//    PC_NEXT_ALIGN_CHECK_EN  when defined, a load whose target has nonzero
//                            low two bits is refused and the unit enters
//                            FAULT. When undefined, targets load verbatim,
//                            FAULT is unreachable and fault is tied low.
// -----------------------------------------------------------------------------
module pc_next_unit #(
    parameter int               WIDTH        = 32,
    parameter int               NSRC         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_00FD,
    localparam int              SW           = (NSRC <= 2) ? 1 : $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW-1:0]         sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond_zero,
    input  logic                  exc_req,
    input  logic                  fault_clr,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      epc_out,
    output logic                  pc_updated,
    output logic                  fault,
    output logic                  sel_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] epc_d;
    logic             updated_d;
    logic             err_d;
    logic             upd;
    logic [WIDTH-1:0] target;
    logic             sel_valid;

    assign upd = pc_write | (pc_write_cond & cond_zero);

    // Source mux. Matching sel against each legal index (instead of slicing
    // with sel directly) keeps an out-of-range sel from reading past the bus
    // and yields the range check as a by-product.
    always_comb begin
        target    = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SW'(i)) begin
                target    = src_data[i*WIDTH +: WIDTH];
                sel_valid = 1'b1;
            end
        end
    end

    // State register plus the PC/EPC datapath and the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_out     <= RESET_VECTOR;
            epc_out    <= '0;
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_out     <= pc_d;
            epc_out    <= epc_d;
            pc_updated <= updated_d;
            sel_err    <= err_d;
        end
    end

    // Next-state and next-datapath decision. The if/else chain encodes the
    // priority: exception, then FAULT handling (fault_clr or hold), then the
    // sel range check, the optional alignment check, and finally the load.
    // fault_clr only matters in FAULT, so in RUN a load proceeds normally.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_out;
        epc_d     = epc_out;
        updated_d = 1'b0;
        err_d     = 1'b0;
        if (exc_req) begin
            pc_d      = EXC_VECTOR;
            epc_d     = pc_out;
            state_d   = ST_RUN;
            updated_d = 1'b1;
        end else if (state_q == ST_FAULT) begin
            if (fault_clr) begin
                state_d = ST_RUN;
            end
        end else if (upd) begin
            if (!sel_valid) begin
                err_d = 1'b1;
`ifdef PC_NEXT_ALIGN_CHECK_EN
            end else if (target[1:0] != 2'b00) begin
                epc_d   = pc_out;
                state_d = ST_FAULT;
`endif
            end else begin
                pc_d      = target;
                updated_d = 1'b1;
            end
        end
    end

    // Output decode of the FSM.
    always_comb begin
`ifdef PC_NEXT_ALIGN_CHECK_EN
        fault = (state_q == ST_FAULT);
`else
        fault = 1'b0;
`endif
    end

endmodule
